// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts single-cycle detect pulses inside a fixed window
// of GATE_CYCLES clocks and publishes the count through a valid/ready
// handshake. Windows run back-to-back while enable is high.
//
// Build option: FREQ_SAT_EN
//   defined   - pulse counter saturates at all-ones (reading clamped)
//   undefined - pulse counter wraps modulo 2^COUNT_W
// The overflow flag behaves the same in both builds.
//
// state  | meaning
// IDLE   | not measuring; pulse_in ignored, result/handshake still served
// GATE   | window open; every cycle sampled, result published at last cycle
module freq_gate_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pulse_in,
    input  logic               freq_ready,
    output logic [COUNT_W-1:0] freq_out,
    output logic               freq_valid,
    output logic               overflow,
    output logic               result_lost,
    output logic               gate_active
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GATE = 1'b1
    } state_t;

    state_t             state_q;
    logic [GW-1:0]      gate_cnt_q;
    logic [COUNT_W-1:0] pulse_cnt_q;
    logic [COUNT_W-1:0] pulse_cnt_d;
    logic               win_ovf_q;
    logic               win_ovf_d;
    logic [COUNT_W-1:0] freq_out_q;
    logic               freq_valid_q;
    logic               overflow_q;
    logic               result_lost_q;
    logic               gate_active_q;
    logic               win_last;
    logic               cnt_at_max;

    // Next pulse count and window overflow status including this cycle's sample
    always_comb begin
        win_last   = (gate_cnt_q == GATE_LAST);
        cnt_at_max = (pulse_cnt_q == {COUNT_W{1'b1}});
        win_ovf_d  = win_ovf_q | (pulse_in & cnt_at_max);
`ifdef FREQ_SAT_EN
        pulse_cnt_d = (pulse_in && !cnt_at_max) ? pulse_cnt_q + COUNT_W'(1) : pulse_cnt_q;
`else
        pulse_cnt_d = pulse_in ? pulse_cnt_q + COUNT_W'(1) : pulse_cnt_q;
`endif
    end

    // Gate sequencing, window counters and registered result/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gate_cnt_q    <= '0;
            pulse_cnt_q   <= '0;
            win_ovf_q     <= 1'b0;
            freq_out_q    <= '0;
            freq_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            result_lost_q <= 1'b0;
            gate_active_q <= 1'b0;
        end else begin
            result_lost_q <= 1'b0;
            if (freq_valid_q && freq_ready) begin
                freq_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q       <= S_GATE;
                        gate_active_q <= 1'b1;
                        gate_cnt_q    <= '0;
                        pulse_cnt_q   <= '0;
                        win_ovf_q     <= 1'b0;
                    end
                end
                S_GATE: begin
                    if (win_last) begin
                        // A new result wins over a same-edge transfer clear
                        freq_out_q    <= pulse_cnt_d;
                        overflow_q    <= win_ovf_d;
                        freq_valid_q  <= 1'b1;
                        result_lost_q <= freq_valid_q & ~freq_ready;
                        gate_cnt_q    <= '0;
                        pulse_cnt_q   <= '0;
                        win_ovf_q     <= 1'b0;
                        if (!enable) begin
                            state_q       <= S_IDLE;
                            gate_active_q <= 1'b0;
                        end
                    end else if (!enable) begin
                        // Partial window is dropped; published result untouched
                        state_q       <= S_IDLE;
                        gate_active_q <= 1'b0;
                    end else begin
                        gate_cnt_q  <= gate_cnt_q + GW'(1);
                        pulse_cnt_q <= pulse_cnt_d;
                        win_ovf_q   <= win_ovf_d;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    gate_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign freq_out    = freq_out_q;
    assign freq_valid  = freq_valid_q;
    assign overflow    = overflow_q;
    assign result_lost = result_lost_q;
    assign gate_active = gate_active_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: instance A (100-cycle window, 16-bit)
// covers counting, handshake, overwrite, abort and reset; instance B
// (300-cycle window, 8-bit) covers counter overflow.
module tb_freq_gate_counter;

    logic        clk;
    logic        rst;
    logic        en_a, pulse_a, rdy_a;
    logic [15:0] out_a;
    logic        valid_a, ovf_a, lost_a, gate_a;
    logic        en_b, pulse_b, rdy_b;
    logic [7:0]  out_b;
    logic        valid_b, ovf_b, lost_b, gate_b;

    int n_vec;
    int n_err;

    freq_gate_counter #(.GATE_CYCLES(100), .COUNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .pulse_in(pulse_a), .freq_ready(rdy_a),
        .freq_out(out_a), .freq_valid(valid_a), .overflow(ovf_a),
        .result_lost(lost_a), .gate_active(gate_a)
    );

    freq_gate_counter #(.GATE_CYCLES(300), .COUNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .pulse_in(pulse_b), .freq_ready(rdy_b),
        .freq_out(out_b), .freq_valid(valid_b), .overflow(ovf_b),
        .result_lost(lost_b), .gate_active(gate_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 100-cycle window on instance A from gate cycle 'start'. kind 0: pulse
    // every 4th cycle, 1: first and last cycle, 2: first n cycles. Counts the
    // steps before the window-end edge that observed freq_valid high.
    task automatic drive_window(input int start, input int kind, input int n, output int early_v);
        early_v = 0;
        for (int k = start; k < 100; k++) begin
            case (kind)
                0:       pulse_a = ((k % 4) == 0);
                1:       pulse_a = (k == 0) || (k == 99);
                default: pulse_a = (k < n);
            endcase
            step();
            if (k < 99 && valid_a) early_v++;
        end
        pulse_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; pulse_a = 1'b0; rdy_a = 1'b0;
        en_b = 1'b0; pulse_b = 1'b0; rdy_b = 1'b0;
        #12;
        n_vec++; if (out_a !== 16'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 || lost_a !== 1'b0 || gate_a !== 1'b0) begin
            n_err++; $display("FAIL reset_a got out=%0d v=%b o=%b l=%b g=%b exp all 0", out_a, valid_a, ovf_a, lost_a, gate_a);
        end
        n_vec++; if (out_b !== 8'd0 || valid_b !== 1'b0 || ovf_b !== 1'b0 || lost_b !== 1'b0 || gate_b !== 1'b0) begin
            n_err++; $display("FAIL reset_b got out=%0d v=%b o=%b l=%b g=%b exp all 0", out_b, valid_b, ovf_b, lost_b, gate_b);
        end
        step();
        rst = 1'b0;
        step();
        n_vec++; if (gate_a !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset gate_active got %b exp 0", gate_a);
        end
    endtask

    task automatic test_basic();
        int ev;
        rdy_a = 1'b1; en_a = 1'b1; pulse_a = 1'b1;  // pulse on entry edge must be ignored
        step();
        n_vec++; if (gate_a !== 1'b1 || valid_a !== 1'b0) begin
            n_err++; $display("FAIL basic_entry got gate=%b valid=%b exp 1/0", gate_a, valid_a);
        end
        drive_window(0, 0, 0, ev);
        n_vec++; if (ev !== 0) begin
            n_err++; $display("FAIL basic_early_valid got %0d cycles exp 0", ev);
        end
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd25 || ovf_a !== 1'b0 || lost_a !== 1'b0) begin
            n_err++; $display("FAIL basic_win1 got v=%b out=%0d o=%b l=%b exp 1/25/0/0", valid_a, out_a, ovf_a, lost_a);
        end
        drive_window(0, 0, 0, ev);
        n_vec++; if (ev !== 0) begin
            n_err++; $display("FAIL basic_valid_pulse got %0d high cycles exp 0", ev);
        end
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd25 || gate_a !== 1'b1) begin
            n_err++; $display("FAIL basic_win2 got v=%b out=%0d g=%b exp 1/25/1", valid_a, out_a, gate_a);
        end
    endtask

    task automatic test_first_last();
        int ev;
        drive_window(0, 1, 0, ev);
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd2) begin
            n_err++; $display("FAIL first_last got v=%b out=%0d exp 1/2", valid_a, out_a);
        end
    endtask

    task automatic test_overwrite();
        int ev;
        pulse_a = 1'b1; rdy_a = 1'b1;  // gate cycle 0; pending result consumed here
        step();
        n_vec++; if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL ovw_consume valid got %b exp 0", valid_a);
        end
        rdy_a = 1'b0;
        drive_window(1, 2, 10, ev);
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd10 || lost_a !== 1'b0) begin
            n_err++; $display("FAIL ovw_win10 got v=%b out=%0d l=%b exp 1/10/0", valid_a, out_a, lost_a);
        end
        drive_window(0, 2, 20, ev);
        n_vec++; if (ev !== 99) begin
            n_err++; $display("FAIL ovw_valid_held got %0d cycles exp 99", ev);
        end
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd20 || lost_a !== 1'b1) begin
            n_err++; $display("FAIL ovw_win20 got v=%b out=%0d l=%b exp 1/20/1", valid_a, out_a, lost_a);
        end
        step();
        n_vec++; if (lost_a !== 1'b0 || valid_a !== 1'b1 || out_a !== 16'd20) begin
            n_err++; $display("FAIL ovw_lost_once got l=%b v=%b out=%0d exp 0/1/20", lost_a, valid_a, out_a);
        end
        rdy_a = 1'b1;
        step();
        n_vec++; if (valid_a !== 1'b0) begin
            n_err++; $display("FAIL ovw_ready_clear valid got %b exp 0", valid_a);
        end
        en_a = 1'b0;
        step();
        step();
        n_vec++; if (gate_a !== 1'b0 || valid_a !== 1'b0) begin
            n_err++; $display("FAIL ovw_disable got g=%b v=%b exp 0/0", gate_a, valid_a);
        end
    endtask

    task automatic test_abort();
        int ev;
        rdy_a = 1'b0; en_a = 1'b1;
        step();
        drive_window(0, 0, 0, ev);
        n_vec++; if (valid_a !== 1'b1 || out_a !== 16'd25) begin
            n_err++; $display("FAIL abort_pending got v=%b out=%0d exp 1/25", valid_a, out_a);
        end
        for (int k = 0; k < 50; k++) begin
            pulse_a = ((k % 4) == 0);
            step();
        end
        en_a = 1'b0; pulse_a = 1'b1;
        step();
        n_vec++; if (gate_a !== 1'b0 || valid_a !== 1'b1 || out_a !== 16'd25) begin
            n_err++; $display("FAIL abort_idle got g=%b v=%b out=%0d exp 0/1/25", gate_a, valid_a, out_a);
        end
        repeat (120) step();
        pulse_a = 1'b0;
        n_vec++; if (gate_a !== 1'b0 || valid_a !== 1'b1 || out_a !== 16'd25 || lost_a !== 1'b0) begin
            n_err++; $display("FAIL abort_hold got g=%b v=%b out=%0d l=%b exp 0/1/25/0", gate_a, valid_a, out_a, lost_a);
        end
    endtask

    task automatic test_reset_mid();
        int ev;
        en_a = 1'b1; pulse_a = 1'b1;
        step();
        repeat (30) step();
        rst = 1'b1;
        #1;
        n_vec++; if (out_a !== 16'd0 || valid_a !== 1'b0 || ovf_a !== 1'b0 || lost_a !== 1'b0 || gate_a !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got out=%0d v=%b o=%b l=%b g=%b exp all 0", out_a, valid_a, ovf_a, lost_a, gate_a);
        end
        step();
        rst = 1'b0; pulse_a = 1'b0; rdy_a = 1'b1;
        step();
        n_vec++; if (gate_a !== 1'b1) begin
            n_err++; $display("FAIL rst_restart_entry gate got %b exp 1", gate_a);
        end
        drive_window(0, 0, 0, ev);
        n_vec++; if (ev !== 0 || valid_a !== 1'b1 || out_a !== 16'd25) begin
            n_err++; $display("FAIL rst_restart_win got early=%0d v=%b out=%0d exp 0/1/25", ev, valid_a, out_a);
        end
        en_a = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_out;
`ifdef FREQ_SAT_EN
        exp_out = 8'd255;
`else
        exp_out = 8'd44;
`endif
        en_b = 1'b1; rdy_b = 1'b1; pulse_b = 1'b1;
        step();
        repeat (300) step();
        n_vec++; if (valid_b !== 1'b1 || out_b !== exp_out || ovf_b !== 1'b1) begin
            n_err++; $display("FAIL ovf_win got v=%b out=%0d o=%b exp 1/%0d/1", valid_b, out_b, ovf_b, exp_out);
        end
        pulse_b = 1'b0;
        step();
        n_vec++; if (valid_b !== 1'b0 || ovf_b !== 1'b1) begin
            n_err++; $display("FAIL ovf_consumed got v=%b o=%b exp 0/1", valid_b, ovf_b);
        end
        repeat (299) step();
        n_vec++; if (valid_b !== 1'b1 || out_b !== 8'd0 || ovf_b !== 1'b0) begin
            n_err++; $display("FAIL ovf_cleared got v=%b out=%0d o=%b exp 1/0/0", valid_b, out_b, ovf_b);
        end
        en_b = 1'b0;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_first_last();
        test_overwrite();
        test_abort();
        test_reset_mid();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
Gated pulse counter that sits directly downstream of the rising-edge detector in the digital frequency meter. It counts the single-cycle detect pulses inside a fixed window of GATE_CYCLES clocks. At the end of each window it publishes the count as the frequency reading, using a valid/ready handshake toward the display/readout stage. Windows run back-to-back while enabled.

Parameters:
GATE_CYCLES, 1000, window length in clk cycles (>=2)
COUNT_W, 16, width of pulse counter and result

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  run measurement; low aborts/idles
pulse_in  input  1  rising-edge pulse from edge detector, 1 clk wide
freq_ready  input  1  downstream accepts result
freq_out  output  COUNT_W  pulses counted in last completed window
freq_valid  output  1  freq_out holds an unconsumed result
overflow  output  1  count of freq_out window exceeded 2^COUNT_W-1
result_lost  output  1  one-cycle pulse: unconsumed result overwritten
gate_active  output  1  high while in GATE state

Behaviour:
- Reset (async, rst=1): state IDLE; gate_cnt=0, pulse_cnt=0; freq_out=0, freq_valid=0, overflow=0, result_lost=0, gate_active=0.
- States: IDLE, GATE.
- IDLE -> GATE on the first clk edge with enable=1. gate_cnt and pulse_cnt are cleared on that transition.
- GATE: gate_active=1; gate_cnt increments every cycle from 0 to GATE_CYCLES-1. pulse_in is sampled on every GATE cycle, including the first and last; each high sample increments pulse_cnt.
- Window end (gate_cnt==GATE_CYCLES-1): on that edge, freq_out <= final count, including that cycle's pulse_in. overflow <= window overflow status. freq_valid <= 1. gate_cnt/pulse_cnt restart at 0.
- After window end: stay in GATE if enable=1, with no dead cycle between windows; otherwise go to IDLE.
- Latency: freq_valid rises 1 cycle after the last window cycle, i.e. GATE_CYCLES cycles after GATE entry.
- enable=0 during GATE: return to IDLE on the next edge. The partial window is discarded. freq_out, freq_valid and overflow are unchanged.
- Handshake: a transfer occurs when freq_valid&freq_ready. freq_valid clears on the next edge unless a new result lands on that same edge, in which case it stays 1 with the new value. freq_out is stable while freq_valid=1 and no new window ends.
- Overwrite: a window ends while freq_valid=1 and freq_ready=0. New result replaces the old one and result_lost pulses for 1 cycle.
- Overflow: pulse_cnt is COUNT_W bits. An increment at all-ones sets the window's overflow flag; the count wrap/saturate behaviour is given under Optional Feature. The overflow flag clears at each window start.
- pulse_in is ignored in IDLE.

Optional Feature:
FREQ_SAT_EN
- Defined: pulse_cnt saturates at 2^COUNT_W-1, so freq_out is clamped on overflow.
- Undefined: pulse_cnt wraps modulo 2^COUNT_W.
- overflow is reported identically in both cases.

Test Plan:
- GATE_CYCLES=100, COUNT_W=16, enable=1, pulse_in high every 4th cycle, freq_ready=1 -> freq_out=25. freq_valid 1-cycle pulse at cycle 100 after GATE entry, then every 100 cycles; overflow=0.
- Exactly 2 pulses, on the first and last GATE cycle of a window -> freq_out=2.
- GATE_CYCLES=300, COUNT_W=8, pulse_in held 1 -> overflow=1. freq_out=44 without FREQ_SAT_EN; freq_out=255 with it.
- freq_ready=0 across two windows at 10 then 20 pulses -> freq_valid stays 1, freq_out becomes 20, result_lost pulses once. Raising freq_ready clears freq_valid next cycle.
- A prior result of 25 is pending; enable drops at gate cycle 50 -> state IDLE, gate_active=0, no new freq_valid, freq_out stays 25.
- rst asserted mid-window with freq_valid=1 -> all outputs 0 immediately. Measurement restarts from gate_cnt=0 after release with enable=1.
